// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, the word geometry and the address error check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    COMMIT,
    RESP
  } dmem_state_t;

  localparam int DMEM_WORD_BYTES = 4;
  localparam int DMEM_WAIT_W     = $clog2(16);

  // Misaligned byte addresses and anything beyond the array's byte span are errors.
  function automatic logic dmem_addr_err(input logic [31:0] addr, input int addr_width);
    logic [31:0] high_bits;
    high_bits = addr >> (addr_width + 2);
    return (addr[1:0] != 2'b00) || (high_bits != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data SRAM: byte-enabled write, registered read.
// Contents and read register are intentionally not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic                       we,
  input  logic [DMEM_WORD_BYTES-1:0] be,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DMEM_WORD_BYTES; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the data-memory request port with programmable wait states.
// One request in flight: accept, wait, commit to the SRAM, then hold the response until taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [DMEM_WAIT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? DMEM_WAIT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_t            state, state_next;
  logic [DMEM_WAIT_W-1:0] wait_cnt, wait_cnt_next;

  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_err;
  logic        rsp_err_q;
  logic        rd_hold;
  logic        ram_en;
  logic [31:0] ram_rdata;

  assign lat_err = dmem_addr_err(lat_addr, ADDR_WIDTH);

  // rd_hold marks that the SRAM read register carries this response's load data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
      rd_hold   <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state == COMMIT) begin
        rsp_err_q <= lat_err;
        rd_hold   <= !lat_write && !lat_err;
      end else if (state == RESP && rsp_ready) begin
        rsp_err_q <= 1'b0;
        rd_hold   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_next    = BUSY;
            wait_cnt_next = WAIT_INIT;
          end else begin
            state_next = COMMIT;
          end
        end
      end
      BUSY: begin
        if (wait_cnt == '0) begin
          state_next = COMMIT;
        end else begin
          wait_cnt_next = wait_cnt - 1'b1;
        end
      end
      COMMIT:  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset arriving on the commit edge cancels the access rather than racing it.
  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
    rsp_err   = rsp_err_q;
    rsp_rdata = rd_hold ? ram_rdata : 32'd0;
    ram_en    = (state == COMMIT) && !lat_err && !reset;
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (lat_write),
    .be    (lat_be),
    .addr  (lat_addr[ADDR_WIDTH+1:2]),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

endmodule
